reg_file_32x32: RTL and testbench

- Storage stage directly upstream of the 32:1 read-select mux in the factorial datapath.
- Holds 32 words of 32 bits, accepts one write per cycle and presents all words in parallel on one flattened bus; word k feeds mux input d(k+1).
- Also runs a sequenced bulk-clear (one entry per cycle) that the controller uses before starting a new factorial run.

---
 rtl/reg_file_32x32_pkg.sv | 14 +
 rtl/reg_file_clr_fsm.sv | 82 ++++++++
 rtl/reg_file_32x32.sv | 62 ++++++
 tb/tb_reg_file_32x32.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_32x32_pkg.sv
// Shared constants and FSM encoding for the 32x32 register file.
// The read-select mux imports the same width constants.
package reg_file_32x32_pkg;

    localparam int WIDTH = 32;  // bits per word
    localparam int AW    = 5;   // address / clear-counter width
    localparam int DEPTH = 32;  // number of entries, equal to 2**AW

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Bulk-clear sequencer for the register file. It holds the state register
// and clear counter, and it decodes busy, clr_done and wr_err. It also
// drives one write enable per entry. In IDLE the enable comes from the
// external write port. In CLEAR it comes from the counter.
module reg_file_clr_fsm
    import reg_file_32x32_pkg::*;
(
    input  logic             clk,
    input  logic             reset_i,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             clr_start_i,
    output logic             busy_o,
    output logic             clr_done_o,
    output logic             wr_err_o,
    output logic [DEPTH-1:0] entry_we_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_entry;

    assign last_entry = (cnt_q == AW'(DEPTH - 1));

    // State and clear-counter registers; reset overrides everything.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE waits for clr_start; CLEAR walks every entry once.
    // NOTE: defaults at the top of each always_comb keep it latch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter is AW bits, so it wraps to 0 as the clear exits.
                cnt_d = cnt_q + 1'b1;
                if (last_entry) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: status flags and the per-entry write-enable decode.
    always_comb begin
        busy_o     = 1'b0;
        clr_done_o = 1'b0;
        wr_err_o   = 1'b0;
        entry_we_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (we_i) begin
                    entry_we_o[wr_addr_i] = 1'b1;
                end
            end
            ST_CLEAR: begin
                busy_o            = 1'b1;
                clr_done_o        = last_entry;
                wr_err_o          = we_i;  // external write is dropped
                entry_we_o[cnt_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_file_32x32.sv
// 32-entry x 32-bit register file that feeds the factorial read-select mux.
// Every word is presented in parallel on q_all, and word k sits at
// bits [WIDTH*k +: WIDTH]. A sequenced bulk clear zeroes one entry per
// cycle while busy is high.
module reg_file_32x32 #(
    parameter int WIDTH = reg_file_32x32_pkg::WIDTH,
    parameter int AW    = reg_file_32x32_pkg::AW,
    parameter int DEPTH = reg_file_32x32_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr_start,
    output logic                   busy,
    output logic                   clr_done,
    output logic                   wr_err,
    output logic [DEPTH*WIDTH-1:0] q_all
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic [WIDTH-1:0] fill_word;

    reg_file_clr_fsm u_clr_fsm (
        .clk         (clk),
        .reset_i     (reset),
        .we_i        (we),
        .wr_addr_i   (wr_addr),
        .clr_start_i (clr_start),
        .busy_o      (busy),
        .clr_done_o  (clr_done),
        .wr_err_o    (wr_err),
        .entry_we_o  (entry_we)
    );

    // While a clear runs, the only enabled entry is the one being zeroed.
    assign fill_word = busy ? '0 : wr_data;

    // Storage array: a reset zeroes every entry; otherwise the enabled entry loads.
    // NOTE: this array is flops, not a RAM, because a reset must zero every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (entry_we[k]) begin
                    mem_q[k] <= fill_word;
                end
            end
        end
    end

    // Flatten the array onto the mux bus. There is no read-during-write bypass.
    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign q_all[WIDTH*g +: WIDTH] = mem_q[g];
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32. The driver applies one cycle of
// stimulus at a time. It pushes the expected outputs for that cycle, which
// come from a behavioural model: an array of words plus a count of the clear
// cycles still remaining. A negedge monitor pops and compares.
module tb_reg_file_32x32;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   reset, we, clr_start;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic                   busy, clr_done, wr_err;
    logic [DEPTH*WIDTH-1:0] q_all;

    reg_file_32x32 dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .wr_err    (wr_err),
        .q_all     (q_all)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DEPTH-1:0][WIDTH-1:0] words;
        logic                        busy;
        logic                        done;
        logic                        err;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               clear_left;   // clear cycles still to run; 0 means idle
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input int k);
        return q_all[WIDTH*k +: WIDTH];
    endfunction

    // Monitor: compares every cycle that has a pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy",     WIDTH'(busy),     WIDTH'(e.busy));
            check("clr_done", WIDTH'(clr_done), WIDTH'(e.done));
            check("wr_err",   WIDTH'(wr_err),   WIDTH'(e.err));
            for (int k = 0; k < DEPTH; k++) begin
                check($sformatf("q_all[%0d]", k), word_of(k), e.words[k]);
            end
        end
    end

    // One clock cycle: drive inputs, push this cycle's expectation, advance the model.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input logic cs);
        exp_t e;
        reset = r; we = w; wr_addr = a; wr_data = d; clr_start = cs;
        for (int k = 0; k < DEPTH; k++) e.words[k] = ref_mem[k];
        e.busy = (clear_left > 0);
        e.done = (clear_left == 1);
        e.err  = (clear_left > 0) && w;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
            clear_left = 0;
        end else if (clear_left > 0) begin
            ref_mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else begin
            if (w) ref_mem[a] = d;
            if (cs) clear_left = DEPTH;
        end
        #1;
        we = 1'b0; clr_start = 1'b0; reset = 1'b0;
    endtask

    task automatic fill(input logic [WIDTH-1:0] val);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, AW'(k), val, 1'b0);
    endtask

    // Runs 40 idle cycles right after a clear has started and counts busy and clr_done.
    task automatic count_clear(input int repulse_at, output int n_busy, output int n_done);
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) n_busy++;
            if (clr_done) n_done++;
            step(1'b0, 1'b0, '0, '0, i == repulse_at);
        end
    endtask

    int nb, nd;

    initial begin
        reset = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        clear_left = 0;

        // Random writes, then a two-cycle reset that must zero everything.
        for (int i = 0; i < 24; i++) step(1'b0, 1'($urandom_range(1)), AW'($urandom), $urandom, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_done", WIDTH'(clr_done), '0);
        check("rst_err",  WIDTH'(wr_err), '0);
        for (int k = 0; k < DEPTH; k++) check("rst_word", word_of(k), '0);

        // Basic writes, visible the cycle after the write edge.
        step(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0);
        step(1'b0, 1'b1, 5'd31, 32'h00000078, 1'b0);
        check("word5",  q_all[191:160],  32'hDEADBEEF);
        check("word31", q_all[1023:992], 32'h00000078);
        step(1'b0, 1'b0, '0, '0, 1'b0);

        // Full bulk clear: busy is high for 32 cycles and clr_done pulses once.
        fill(32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        count_clear(-1, nb, nd);
        check("clear_busy_cycles", WIDTH'(nb), 32);
        check("clear_done_pulses", WIDTH'(nd), 1);

        // A write during the clear is dropped and flagged; entry 20 keeps its value until cleared.
        fill(32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 5'd20, 32'h00001234, 1'b0);
        check("word20_kept", word_of(20), 32'hFFFFFFFF);
        count_clear(-1, nb, nd);
        check("word20_final", word_of(20), '0);

        // A write together with clr_start lands first; a repeated clr_start mid-clear is ignored.
        step(1'b0, 1'b1, 5'd0, 32'h0000AAAA, 1'b1);
        check("sim_word0", word_of(0), 32'h0000AAAA);
        check("sim_busy",  WIDTH'(busy), 32'd1);
        count_clear(10, nb, nd);
        check("repulse_busy_cycles", WIDTH'(nb), 32);
        check("sim_word0_cleared",   word_of(0), '0);

        // A reset mid-clear aborts it, and a fresh clear then runs in full.
        fill(32'h5A5A5A5A);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check("midrst_busy",   WIDTH'(busy), '0);
        check("midrst_word31", word_of(31), '0);
        step(1'b0, 1'b1, 5'd31, 32'h0BADF00D, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        count_clear(-1, nb, nd);
        check("restart_busy_cycles", WIDTH'(nb), 32);
        check("restart_done_pulses", WIDTH'(nd), 1);

        // Randomized traffic, with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic r, w, cs;
            r  = ($urandom_range(99) == 0);
            w  = !r && ($urandom_range(1) == 1);
            cs = ($urandom_range(19) == 0);
            step(r, w, AW'($urandom), $urandom, cs);
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
